spi_xip_ctrl: RTL and testbench

//  Sequencer/arbiter between the APB bus and the SPI master's Wishbone register port.
//  APB accesses to the SPI register window pass through unchanged.
//  APB reads in the flash window become a complete SPI flash READ (0x03) transaction,
//  and the 32-bit word is returned on APB (execute-in-place).

---
 rtl/spi_xip_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_spi_xip_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xip_ctrl.sv
// spi_xip_ctrl: sequencer/arbiter between the APB crossbar and the SPI master's Wishbone port.
// APB accesses to the SPI register window are forwarded as single Wishbone cycles. APB reads in
// the flash window are expanded into a complete SPI flash READ (0x03) transaction, and the
// resulting word is returned on APB (execute-in-place).
// Optional feature: define SPI_XIP_HITBUF_EN to add a one-entry read buffer that answers
// repeated reads of the same flash word without Wishbone traffic.

module spi_xip_ctrl #(
  parameter logic [31:0] FLASH_BASE    = 32'h3000_0000,
  parameter logic [31:0] FLASH_END     = 32'h3fff_ffff,
  parameter logic [31:0] SPI_BASE      = 32'h1000_1000,
  parameter logic [31:0] SPI_END       = 32'h1000_1fff,
  parameter logic [31:0] SPI_DIVIDER   = 32'h0000_0001,
  parameter logic [7:0]  FLASH_SS_MASK = 8'h01
) (
  input  logic        clock,
  input  logic        reset,
  // APB slave side
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  // Wishbone master side
  output logic [4:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  typedef enum logic [3:0] {
    StIdle, StPass, StTx1, StDiv, StSs, StCtrl, StPoll, StRx0, StSsClr, StResp
  } state_e;

  state_e      state;
  state_e      step_next;
  logic [21:0] addr_q;   // flash word address, in_paddr[23:2]
  logic [31:0] rdata_q;  // data returned in RESP
  logic        err_q;    // error returned in RESP
  logic [4:0]  step_adr;
  logic [31:0] step_dat;
  logic        step_we;
  logic        req;
  logic        in_spi_win;
  logic        in_flash_win;
  logic        wb_done;

`ifdef SPI_XIP_HITBUF_EN
  logic        hb_valid;
  logic [21:0] hb_tag;
  logic [31:0] hb_data;
  logic        hb_hit;

  assign hb_hit = hb_valid && (hb_tag == in_paddr[23:2]);
`endif

  // The pready guard stops the still-held request from being decoded again during the pulse.
  assign req          = in_psel & in_penable & ~in_pready;
  assign in_spi_win   = (in_paddr >= SPI_BASE) && (in_paddr <= SPI_END);
  assign in_flash_win = (in_paddr >= FLASH_BASE) && (in_paddr <= FLASH_END);
  assign wb_done      = wb_cyc_o & (wb_ack_i | wb_err_i);

  // Wishbone access issued by each flash sequencer step.
  always_comb begin
    step_adr = 5'h00;
    step_dat = 32'h0;
    step_we  = 1'b0;
    case (state)
      StTx1: begin
        step_adr = 5'h04;
        step_dat = {8'h03, addr_q, 2'b00};
        step_we  = 1'b1;
      end
      StDiv: begin
        step_adr = 5'h14;
        step_dat = SPI_DIVIDER;
        step_we  = 1'b1;
      end
      StSs: begin
        step_adr = 5'h18;
        step_dat = {24'h0, FLASH_SS_MASK};
        step_we  = 1'b1;
      end
      StCtrl: begin
        step_adr = 5'h10;
        step_dat = 32'h0000_0140;  // GO_BSY=1, CHAR_LEN=64
        step_we  = 1'b1;
      end
      StPoll: step_adr = 5'h10;
      StRx0:  step_adr = 5'h00;
      StSsClr: begin
        step_adr = 5'h18;
        step_we  = 1'b1;
      end
      default: ;
    endcase
  end

  // Successor of each flash step after an error-free completion.
  always_comb begin
    step_next = StIdle;
    case (state)
      StTx1:   step_next = StDiv;
      StDiv:   step_next = StSs;
      StSs:    step_next = StCtrl;
      StCtrl:  step_next = StPoll;
      StPoll:  step_next = wb_dat_i[8] ? StPoll : StRx0;  // GO_BSY still set: poll again
      StRx0:   step_next = StSsClr;
      StSsClr: step_next = StResp;
      default: step_next = StIdle;
    endcase
  end

  // Main FSM with registered APB and Wishbone outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      addr_q     <= 22'h0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
      in_pready  <= 1'b0;
      in_prdata  <= 32'h0;
      in_pslverr <= 1'b0;
      wb_adr_o   <= 5'h00;
      wb_dat_o   <= 32'h0;
      wb_sel_o   <= 4'h0;
      wb_we_o    <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_cyc_o   <= 1'b0;
`ifdef SPI_XIP_HITBUF_EN
      hb_valid   <= 1'b0;
      hb_tag     <= 22'h0;
      hb_data    <= 32'h0;
`endif
    end else begin
      case (state)
        StIdle: begin
          in_pready  <= 1'b0;
          in_prdata  <= 32'h0;
          in_pslverr <= 1'b0;
          if (req) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            addr_q  <= in_paddr[23:2];
            if (in_spi_win) begin
              // Passthrough cycle starts straight away with the APB fields.
              wb_adr_o <= in_paddr[4:0];
              wb_dat_o <= in_pwdata;
              wb_sel_o <= in_pstrb;
              wb_we_o  <= in_pwrite;
              wb_stb_o <= 1'b1;
              wb_cyc_o <= 1'b1;
              state    <= StPass;
`ifdef SPI_XIP_HITBUF_EN
              if (in_pwrite) hb_valid <= 1'b0;
`endif
            end else if (in_flash_win && !in_pwrite) begin
`ifdef SPI_XIP_HITBUF_EN
              if (hb_hit) begin
                rdata_q <= hb_data;
                state   <= StResp;
              end else begin
                state <= StTx1;
              end
`else
              state <= StTx1;
`endif
            end else begin
              err_q <= 1'b1;
              state <= StResp;
            end
          end
        end

        StPass: begin
          if (wb_done) begin
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            rdata_q  <= wb_dat_i;
            err_q    <= wb_err_i;
            state    <= StResp;
          end
        end

        StTx1, StDiv, StSs, StCtrl, StPoll, StRx0, StSsClr: begin
          if (!wb_cyc_o) begin
            wb_adr_o <= step_adr;
            wb_dat_o <= step_dat;
            wb_sel_o <= 4'hF;
            wb_we_o  <= step_we;
            wb_stb_o <= 1'b1;
            wb_cyc_o <= 1'b1;
          end else if (wb_done) begin
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            if (wb_err_i) begin
              // Still try to deselect the flash unless the deselect itself failed.
              err_q <= 1'b1;
              state <= (state == StSsClr) ? StResp : StSsClr;
`ifdef SPI_XIP_HITBUF_EN
              hb_valid <= 1'b0;
`endif
            end else begin
              if (state == StRx0) begin
                // Flash byte at a*4 arrives first, i.e. in the MSB of the shift register.
                rdata_q <= {wb_dat_i[7:0], wb_dat_i[15:8], wb_dat_i[23:16], wb_dat_i[31:24]};
              end
`ifdef SPI_XIP_HITBUF_EN
              if (state == StSsClr && !err_q) begin
                hb_valid <= 1'b1;
                hb_tag   <= addr_q;
                hb_data  <= rdata_q;
              end
`endif
              state <= step_next;
            end
          end
        end

        StResp: begin
          in_pready  <= 1'b1;
          in_prdata  <= rdata_q;
          in_pslverr <= err_q;
          state      <= StIdle;
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xip_ctrl.sv
// tb_spi_xip_ctrl: randomized bench for spi_xip_ctrl against a behavioural reference model.
// The Wishbone side is a small SPI-master/flash model; the hit buffer model is active when
// SPI_XIP_HITBUF_EN is defined.

module tb_spi_xip_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] in_paddr;
  logic        in_psel;
  logic        in_penable;
  logic        in_pwrite;
  logic [31:0] in_pwdata;
  logic [3:0]  in_pstrb;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        in_pslverr;
  logic [4:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  always #5 clock = ~clock;

  spi_xip_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .in_paddr   (in_paddr),
    .in_psel    (in_psel),
    .in_penable (in_penable),
    .in_pwrite  (in_pwrite),
    .in_pwdata  (in_pwdata),
    .in_pstrb   (in_pstrb),
    .in_pready  (in_pready),
    .in_prdata  (in_prdata),
    .in_pslverr (in_pslverr),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_sel_o   (wb_sel_o),
    .wb_we_o    (wb_we_o),
    .wb_stb_o   (wb_stb_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .wb_err_i   (wb_err_i)
  );

  typedef struct {
    logic        we;
    logic [4:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] rdat;
    logic        err;
  } wb_rec_t;

  wb_rec_t     wb_log[$];
  int          n_total = 0;
  int          n_bad = 0;
  int          cyc_cnt = 0;
  int          last_ack_cyc = 0;
  int          cyc_seen_cnt = 0;
  int          ack_dly = 0;
  int          poll_busy = 0;
  int          err_on = -1;
  int          log_base = 0;
  int          dly_q;
  int          busy_q;
  logic [31:0] tx_q;
  logic [31:0] noise_q;
  logic [31:0] slave_rd;
  logic [23:0] tx_a;

  // Reference hit buffer state
  bit          hb_v = 1'b0;
  logic [21:0] hb_t = 22'h0;
  logic [31:0] hb_d = 32'h0;

  // Flash contents: fixed bytes 11,22,33,44 at 0x10..0x13, a hash elsewhere.
  function automatic logic [7:0] fb(input logic [23:0] x);
    case (x)
      24'h10:  return 8'h11;
      24'h11:  return 8'h22;
      24'h12:  return 8'h33;
      24'h13:  return 8'h44;
      default: return (x[7:0] * 8'd37) ^ x[15:8] ^ x[23:16] ^ 8'hA5;
    endcase
  endfunction

  // Little-endian word the APB master should see for a flash read.
  function automatic logic [31:0] exp_word(input logic [31:0] addr);
    logic [23:0] b;
    b = {addr[23:2], 2'b00};
    return {fb(b + 24'd3), fb(b + 24'd2), fb(b + 24'd1), fb(b)};
  endfunction

  function automatic logic [41:0] key(input logic we, input logic [4:0] adr, input logic [3:0] sel,
                                      input logic [31:0] dat);
    return {we, adr, sel, we ? dat : 32'h0};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // SPI master model: RX returns the 4 bytes clocked in after the command, first byte in MSB.
  assign tx_a = tx_q[23:0];
  always_comb begin
    slave_rd = noise_q;
    if (wb_adr_o == 5'h10) slave_rd = {23'h0, busy_q != 0, 8'h40};
    else if (wb_adr_o == 5'h00)
      slave_rd = {fb(tx_a), fb(tx_a + 24'd1), fb(tx_a + 24'd2), fb(tx_a + 24'd3)};
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_ack_i <= 1'b0;
      wb_err_i <= 1'b0;
      wb_dat_i <= 32'h0;
      busy_q   <= 0;
      dly_q    <= 0;
      tx_q     <= 32'h0;
      noise_q  <= 32'h0;
    end else begin
      noise_q  <= $urandom;
      wb_ack_i <= 1'b0;
      wb_err_i <= 1'b0;
      if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i) begin
        if (dly_q < ack_dly) begin
          dly_q <= dly_q + 1;
        end else begin
          dly_q    <= 0;
          wb_dat_i <= slave_rd;
          if (wb_log.size() - log_base == err_on) wb_err_i <= 1'b1;
          else wb_ack_i <= 1'b1;
          wb_log.push_back('{we: wb_we_o, adr: wb_adr_o, dat: wb_dat_o, sel: wb_sel_o,
                             rdat: slave_rd, err: (wb_log.size() - log_base == err_on)});
          if (wb_we_o && wb_adr_o == 5'h04) tx_q <= wb_dat_o;
          if (wb_we_o && wb_adr_o == 5'h10 && wb_dat_o[8]) busy_q <= poll_busy;
          if (!wb_we_o && wb_adr_o == 5'h10 && busy_q != 0) busy_q <= busy_q - 1;
        end
      end
    end
  end

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clock) begin
    if (wb_ack_i || wb_err_i) last_ack_cyc <= cyc_cnt;
    if (wb_cyc_o) cyc_seen_cnt <= cyc_seen_cnt + 1;
  end

  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata,
                          output logic slverr, output int pready_cyc);
    bit got;
    got        = 1'b0;
    rdata      = 32'h0;
    slverr     = 1'b0;
    pready_cyc = 0;
    @(posedge clock); #1;
    in_paddr   = addr;
    in_pwrite  = wr;
    in_pwdata  = wdata;
    in_pstrb   = strb;
    in_psel    = 1'b1;
    in_penable = 1'b0;
    @(posedge clock); #1;
    in_penable = 1'b1;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clock);
      if (in_pready) begin
        got        = 1'b1;
        rdata      = in_prdata;
        slverr     = in_pslverr;
        pready_cyc = cyc_cnt;
      end
    end
    check_eq("pready_seen", 64'(got), 64'd1);
    @(posedge clock); #1;
    in_psel    = 1'b0;
    in_penable = 1'b0;
    check_eq("pready_pulse", 64'(in_pready), 64'd0);
  endtask

  task automatic flash_read(input logic [31:0] addr, input int polls, input int errk,
                            output logic [31:0] rd);
    logic        se;
    int          pc;
    int          n;
    bit          hit;
    logic [41:0] exp_q[$];
    wb_rec_t     r;
    poll_busy = polls;
    err_on    = errk;
    log_base  = wb_log.size();
    hit       = 1'b0;
`ifdef SPI_XIP_HITBUF_EN
    hit = hb_v && (hb_t == addr[23:2]);
`endif
    apb_xfer(addr, 1'b0, $urandom, 4'hF, rd, se, pc);
    n = wb_log.size() - log_base;
    if (hit) begin
      check_eq("hit_nacc", 64'(n), 64'd0);
      check_eq("hit_data", 64'(rd), 64'(hb_d));
      check_eq("hit_err", 64'(se), 64'd0);
    end else begin
      exp_q.push_back(key(1'b1, 5'h04, 4'hF, {8'h03, addr[23:2], 2'b00}));
      exp_q.push_back(key(1'b1, 5'h14, 4'hF, 32'h1));
      exp_q.push_back(key(1'b1, 5'h18, 4'hF, 32'h1));
      exp_q.push_back(key(1'b1, 5'h10, 4'hF, 32'h140));
      for (int i = 0; i <= polls; i++) exp_q.push_back(key(1'b0, 5'h10, 4'hF, 32'h0));
      exp_q.push_back(key(1'b0, 5'h00, 4'hF, 32'h0));
      exp_q.push_back(key(1'b1, 5'h18, 4'hF, 32'h0));
      if (errk >= 0 && errk < exp_q.size() - 1) begin
        while (exp_q.size() > errk + 1) void'(exp_q.pop_back());
        exp_q.push_back(key(1'b1, 5'h18, 4'hF, 32'h0));
      end
      check_eq("flash_nacc", 64'(n), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < n; i++) begin
        r = wb_log[log_base + i];
        check_eq($sformatf("flash_acc%0d", i), 64'(key(r.we, r.adr, r.sel, r.dat)),
                 64'(exp_q[i]));
      end
      if (errk < 0) begin
        check_eq("flash_data", 64'(rd), 64'(exp_word(addr)));
        check_eq("flash_err", 64'(se), 64'd0);
        hb_v = 1'b1;
        hb_t = addr[23:2];
        hb_d = exp_word(addr);
      end else begin
        check_eq("flash_errflag", 64'(se), 64'd1);
        hb_v = 1'b0;
      end
    end
  endtask

  task automatic pass_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                           input logic [3:0] strb, input bit inj_err);
    logic [31:0] rd;
    logic        se;
    int          pc;
    int          n;
    wb_rec_t     r;
    err_on   = inj_err ? 0 : -1;
    log_base = wb_log.size();
    apb_xfer(addr, wr, wd, strb, rd, se, pc);
    n = wb_log.size() - log_base;
    check_eq("pass_nacc", 64'(n), 64'd1);
    if (n >= 1) begin
      r = wb_log[log_base];
      check_eq("pass_acc", 64'(key(r.we, r.adr, r.sel, r.dat)), 64'(key(wr, addr[4:0], strb, wd)));
      check_eq("pass_data", 64'(rd), 64'(r.rdat));
      check_eq("pass_err", 64'(se), 64'(inj_err));
      check_eq("pass_lat", 64'(pc - last_ack_cyc), 64'd2);
    end
    if (wr) hb_v = 1'b0;
  endtask

  task automatic bad_xfer(input logic [31:0] addr, input logic wr);
    logic [31:0] rd;
    logic        se;
    int          pc;
    int          c0;
    err_on = -1;
    c0     = cyc_seen_cnt;
    apb_xfer(addr, wr, $urandom, 4'hF, rd, se, pc);
    check_eq("bad_err", 64'(se), 64'd1);
    check_eq("bad_nocyc", 64'(cyc_seen_cnt - c0), 64'd0);
  endtask

  task automatic reset_mid_poll();
    bit seen;
    seen      = 1'b0;
    poll_busy = 100;
    err_on    = -1;
    ack_dly   = 0;
    @(posedge clock); #1;
    in_paddr   = 32'h3000_0040;
    in_pwrite  = 1'b0;
    in_psel    = 1'b1;
    in_penable = 1'b0;
    @(posedge clock); #1;
    in_penable = 1'b1;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clock);
      if (wb_cyc_o && !wb_we_o && wb_adr_o == 5'h10) seen = 1'b1;
    end
    check_eq("poll_reached", 64'(seen), 64'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    check_eq("rst_wb", 64'({wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o}), 64'd0);
    check_eq("rst_apb", 64'({in_pready, in_prdata, in_pslverr}), 64'd0);
    in_psel    = 1'b0;
    in_penable = 1'b0;
    hb_v       = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] last_flash;
    logic [31:0] a;
    int          kind;
    int          polls;
    int          errk;
    reset      = 1'b1;
    in_paddr   = 32'h0;
    in_psel    = 1'b0;
    in_penable = 1'b0;
    in_pwrite  = 1'b0;
    in_pwdata  = 32'h0;
    in_pstrb   = 4'h0;
    last_flash = 32'h3000_0010;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("reset_wb", 64'({wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o}), 64'd0);
    check_eq("reset_apb", 64'({in_pready, in_prdata, in_pslverr}), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Directed cases
    ack_dly = 1;
    flash_read(32'h3000_0010, 0, -1, rd);
    check_eq("t1_data", 64'(rd), 64'h4433_2211);
    pass_xfer(32'h1000_1014, 1'b1, 32'h5, 4'hF, 1'b0);
    bad_xfer(32'h3000_0000, 1'b1);
    bad_xfer(32'h2000_0000, 1'b0);
    ack_dly = 0;
    flash_read(32'h3000_0020, 5, -1, rd);
    reset_mid_poll();
    flash_read(32'h3000_0004, 1, -1, rd);
    flash_read(32'h3000_0008, 0, -1, rd);
    flash_read(32'h3000_0008, 0, -1, rd);
    pass_xfer(32'h1000_1018, 1'b1, 32'h0, 4'hF, 1'b0);
    flash_read(32'h3000_0008, 0, -1, rd);
    flash_read(32'h3100_0103, 0, 2, rd);
    flash_read(32'h3000_0200, 1, 7, rd);
    pass_xfer(32'h1000_1000, 1'b0, 32'h0, 4'hF, 1'b1);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      kind    = int'($urandom_range(0, 9));
      ack_dly = int'($urandom_range(0, 3));
      if (kind <= 3 || kind == 9) begin
        if (kind == 9 || $urandom_range(0, 2) == 0) a = last_flash;
        else a = 32'h3000_0000 | ($urandom & 32'h0fff_ffff);
        polls = int'($urandom_range(0, 3));
        errk  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 6 + polls)) : -1;
        flash_read(a, polls, errk, rd);
        last_flash = a;
      end else if (kind <= 6) begin
        pass_xfer(32'h1000_1000 | ($urandom & 32'h0000_0fff), 1'($urandom_range(0, 1)),
                  $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
      end else begin
        case ($urandom_range(0, 4))
          0: bad_xfer(32'h3000_0000 | ($urandom & 32'h0fff_ffff), 1'b1);
          1: bad_xfer(32'h1000_0ffc, 1'($urandom_range(0, 1)));
          2: bad_xfer(32'h1000_2000, 1'($urandom_range(0, 1)));
          3: bad_xfer(32'h4000_0000, 1'b0);
          default: bad_xfer(32'h2fff_fffc, 1'b0);
        endcase
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
